// File: rtl/legv8_pkg.sv
// Shared encodings for the multicycle LEGv8 controller: FSM states, opcode patterns,
// ALUOp codes and ALU operand-B selectors.
package legv8_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_LDWB    = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_CBZ     = 4'd8,
        S_BR      = 4'd9,
        S_HALT    = 4'd15
    } state_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic is_rtype(input logic [10:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    endfunction

endpackage

// File: rtl/legv8_mem_watchdog.sv
// Memory-wait watchdog: counts unacknowledged request cycles and raises a sticky
// bus_error when MAX_WAIT is reached without an ack (MAX_WAIT = 0 disables it).
module legv8_mem_watchdog #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ack,
    output logic timeout,
    output logic bus_error
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT    = CW'(MAX_WAIT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_error_q, bus_error_d;
    logic          waiting;

    assign waiting = mem_req && !mem_ack;
    // This cycle would be the MAX_WAIT-th unacknowledged one; an ack in it wins.
    assign timeout = (MAX_WAIT != 0) && waiting && (cnt_q == LIMIT_M1);

    always_comb begin
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q | timeout;
        if (!waiting) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath with a shared req/ack memory.
// Build option LEGV8_ILLEGAL_TRAP_EN adds an 'illegal' output and traps undecodable opcodes.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int OPCODE_W = 11
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg2loc,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ALUOp0,
    output logic                ALUOp1,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [3:0]          state,
    output logic                bus_error
`ifdef LEGV8_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);
    state_e     state_q, state_d;
    logic       is_r, is_ldur, is_stur, is_cbz, is_b, timeout;
    logic       req_c, we_c, iord_c;
    logic       irw_c, pcw_c, pcs_c, r2l_c, srca_c, rw_c, m2r_c;
    logic [1:0] srcb_c, aluop_c;
`ifdef LEGV8_ILLEGAL_TRAP_EN
    logic       illegal_q, illegal_d;
`endif

    assign is_r    = is_rtype(opcode);
    assign is_ldur = (opcode == OP_LDUR);
    assign is_stur = (opcode == OP_STUR);
    assign is_cbz  = (opcode[10:3] == OP_CBZ);
    assign is_b    = (opcode[10:5] == OP_B);

    always_comb begin
        req_c  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        we_c   = (state_q == S_MEMWR);
        iord_c = (state_q == S_MEMRD) || (state_q == S_MEMWR);
    end

    legv8_mem_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
        .clk       (clk),
        .rst_n     (reset_n),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .timeout   (timeout),
        .bus_error (bus_error)
    );

    always_comb begin
        state_d = state_q;
        irw_c   = 1'b0;
        pcw_c   = 1'b0;
        pcs_c   = 1'b0;
        r2l_c   = 1'b0;
        srca_c  = 1'b0;
        srcb_c  = SRCB_REG;
        aluop_c = ALUOP_ADD;
        rw_c    = 1'b0;
        m2r_c   = 1'b0;
`ifdef LEGV8_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_FETCH: begin
                srcb_c = SRCB_FOUR;
                if (timeout) begin
                    state_d = S_HALT;
                end else if (mem_ack) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                srcb_c = SRCB_IMM_SH;
                r2l_c  = is_stur || is_cbz;
                if (is_r)                   state_d = S_REXEC;
                else if (is_ldur || is_stur) state_d = S_MEMADDR;
                else if (is_cbz)            state_d = S_CBZ;
                else if (is_b)              state_d = S_BR;
                else begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`else
                    state_d   = S_FETCH;
`endif
                end
            end
            S_MEMADDR: begin
                srca_c  = 1'b1;
                srcb_c  = SRCB_IMM;
                state_d = is_ldur ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (timeout)      state_d = S_HALT;
                else if (mem_ack) state_d = S_LDWB;
            end
            S_LDWB: begin
                rw_c    = 1'b1;
                m2r_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                r2l_c = 1'b1;
                if (timeout)      state_d = S_HALT;
                else if (mem_ack) state_d = S_FETCH;
            end
            S_REXEC: begin
                srca_c  = 1'b1;
                aluop_c = ALUOP_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                rw_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_CBZ: begin
                srca_c  = 1'b1;
                aluop_c = ALUOP_PASSB;
                r2l_c   = 1'b1;
                pcw_c   = zero;
                pcs_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_BR: begin
                pcw_c   = 1'b1;
                pcs_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
`ifdef LEGV8_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef LEGV8_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Reset parks the FSM in FETCH, which would otherwise request memory; gating with
    // reset_n keeps every strobe low while reset is held and drops them asynchronously.
    assign mem_req    = reset_n & req_c;
    assign mem_we     = reset_n & we_c;
    assign iord       = reset_n & iord_c;
    assign ir_write   = reset_n & irw_c;
    assign pc_write   = reset_n & pcw_c;
    assign pc_src     = reset_n & pcs_c;
    assign reg2loc    = reset_n & r2l_c;
    assign alu_src_a  = reset_n & srca_c;
    assign alu_src_b  = reset_n ? srcb_c : SRCB_REG;
    assign ALUOp1     = reset_n & aluop_c[1];
    assign ALUOp0     = reset_n & aluop_c[0];
    assign reg_write  = reset_n & rw_c;
    assign mem_to_reg = reset_n & m2r_c;
    assign state      = state_q;
`ifdef LEGV8_ILLEGAL_TRAP_EN
    assign illegal    = illegal_q;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: instruction-level reference model pushes
// per-cycle expected control words; a negedge monitor pops and compares them.
module tb_legv8_multicycle_ctrl;
    localparam int MAX_WAIT = 4;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [7:0]  T_CBZ8 = 8'b10110100;
    localparam logic [5:0]  T_B6   = 6'b000101;

    localparam int P_RESET = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADDR = 3, P_MEMRD = 4,
                   P_LDWB = 5, P_MEMWR = 6, P_REXEC = 7, P_RWB = 8, P_CBZ = 9, P_BR = 10,
                   P_HALT = 11;
    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

    typedef struct packed {
        logic [3:0] st;
        logic req, we, iord, irw, pcw, pcs, r2l, srca;
        logic [1:0] srcb;
        logic op1, op0, rw, m2r, berr;
    } exp_t;

    typedef struct {
        exp_t  e;
        logic  ill;
        string tag;
    } item_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg2loc, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ALUOp0, ALUOp1, reg_write, mem_to_reg, bus_error;
    logic [3:0]  state;
`ifdef LEGV8_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    logic  exp_berr = 1'b0;
    logic  exp_ill = 1'b0;

    legv8_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .OPCODE_W(11)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALUOp0(ALUOp0), .ALUOp1(ALUOp1), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .state(state), .bus_error(bus_error)
`ifdef LEGV8_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == T_ADD || op == T_SUB || op == T_AND || op == T_ORR) return C_R;
        if (op == T_LDUR) return C_LD;
        if (op == T_STUR) return C_ST;
        if (hi8 == T_CBZ8) return C_CBZ;
        if (hi6 == T_B6) return C_B;
        return C_ILL;
    endfunction

    // Expected control word for one cycle of a given instruction phase.
    function automatic exp_t ctl(input int ph, input logic ack, input logic z,
                                 input logic [10:0] op, input logic berr);
        exp_t e;
        e = '0;
        e.berr = berr;
        case (ph)
            P_FETCH:   begin e.st = 4'd0; e.req = 1; e.srcb = 2'b01; e.irw = ack; e.pcw = ack; end
            P_DECODE:  begin e.st = 4'd1; e.srcb = 2'b11;
                             e.r2l = (classify(op) == C_ST) || (classify(op) == C_CBZ); end
            P_MEMADDR: begin e.st = 4'd2; e.srca = 1; e.srcb = 2'b10; end
            P_MEMRD:   begin e.st = 4'd3; e.req = 1; e.iord = 1; end
            P_LDWB:    begin e.st = 4'd4; e.rw = 1; e.m2r = 1; end
            P_MEMWR:   begin e.st = 4'd5; e.req = 1; e.we = 1; e.iord = 1; e.r2l = 1; end
            P_REXEC:   begin e.st = 4'd6; e.srca = 1; e.op1 = 1; end
            P_RWB:     begin e.st = 4'd7; e.rw = 1; end
            P_CBZ:     begin e.st = 4'd8; e.srca = 1; e.op0 = 1; e.r2l = 1; e.pcw = z; e.pcs = 1; end
            P_BR:      begin e.st = 4'd9; e.pcw = 1; e.pcs = 1; end
            P_HALT:    begin e.st = 4'd15; end
            default:   e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        item_t it;
        exp_t  act;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg2loc,
                   alu_src_a, alu_src_b, ALUOp1, ALUOp0, reg_write, mem_to_reg, bus_error};
            checks++;
            if (act !== it.e) begin
                errors++;
                $display("FAIL %s @%0t: got st/req/we/iord/irw/pcw/pcs/r2l/sa/sb/op/rw/m2r/be=%b required %b",
                         it.tag, $time, act, it.e);
            end
`ifdef LEGV8_ILLEGAL_TRAP_EN
            checks++;
            if (illegal !== it.ill) begin
                errors++;
                $display("FAIL %s illegal @%0t: got %b required %b", it.tag, $time, illegal, it.ill);
            end
`endif
        end
    end

    task automatic step(input int ph, input logic ack, input logic z, input logic [10:0] op,
                        input string tag);
        item_t it;
        mem_ack = ack;
        zero    = z;
        opcode  = op;
        it.e    = ctl(ph, ack, z, op, exp_berr);
        it.ill  = (ph == P_RESET) ? 1'b0 : exp_ill;
        it.tag  = tag;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        exp_berr = 1'b0;
        exp_ill  = 1'b0;
        step(P_RESET, 1'b1, 1'($urandom), opcode, "reset");
        step(P_RESET, 1'($urandom), 1'($urandom), opcode, "reset");
        reset_n = 1'b1;
    endtask

    task automatic run_instr(input logic [10:0] op, input int fw, input int mw, input logic z,
                             input string tag);
        int cls;
        cls = classify(op);
        for (int k = 0; k <= fw; k++) step(P_FETCH, (k == fw), 1'($urandom), op, {tag, " fetch"});
        step(P_DECODE, 1'($urandom), 1'($urandom), op, {tag, " decode"});
        case (cls)
            C_R: begin
                step(P_REXEC, 1'($urandom), 1'($urandom), op, {tag, " rexec"});
                step(P_RWB, 1'($urandom), 1'($urandom), op, {tag, " rwb"});
            end
            C_LD: begin
                step(P_MEMADDR, 1'($urandom), 1'($urandom), op, {tag, " memaddr"});
                for (int k = 0; k <= mw; k++) step(P_MEMRD, (k == mw), 1'($urandom), op, {tag, " memrd"});
                step(P_LDWB, 1'($urandom), 1'($urandom), op, {tag, " ldwb"});
            end
            C_ST: begin
                step(P_MEMADDR, 1'($urandom), 1'($urandom), op, {tag, " memaddr"});
                for (int k = 0; k <= mw; k++) step(P_MEMWR, (k == mw), 1'($urandom), op, {tag, " memwr"});
            end
            C_CBZ: step(P_CBZ, 1'($urandom), z, op, {tag, " cbz"});
            C_B:   step(P_BR, 1'($urandom), 1'($urandom), op, {tag, " br"});
            default: begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
                exp_ill = 1'b1;
                step(P_HALT, 1'($urandom), 1'($urandom), op, {tag, " trap halt"});
                step(P_HALT, 1'b1, 1'($urandom), op, {tag, " trap halt"});
                do_reset();
`endif
            end
        endcase
    endtask

    initial begin
        logic [10:0] rops [4];
        logic [10:0] op, r;
        rops = '{T_ADD, T_SUB, T_AND, T_ORR};

        @(posedge clk);
        #1;
        step(P_RESET, 1'b1, 1'b1, T_ADD, "reset hold");
        step(P_RESET, 1'b1, 1'b0, T_ADD, "reset hold");
        reset_n = 1'b1;

        run_instr(T_ADD, 0, 0, 1'b0, "add");
        run_instr(T_LDUR, 0, 3, 1'b0, "ldur wait3");
        run_instr({T_CBZ8, 3'b101}, 0, 0, 1'b1, "cbz taken");
        run_instr({T_CBZ8, 3'b010}, 0, 0, 1'b0, "cbz not taken");
        run_instr(T_STUR, 2, 3, 1'b0, "stur");
        run_instr({T_B6, 5'b10011}, 1, 0, 1'b0, "b");

        for (int n = 0; n < 60; n++) begin
            r = 11'($urandom);
            case ($urandom_range(0, 6))
                0: op = rops[$urandom_range(0, 3)];
                1: op = T_LDUR;
                2: op = T_STUR;
                3: op = {T_CBZ8, r[2:0]};
                4: op = {T_B6, r[4:0]};
                default: op = r;
            endcase
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "rand");
        end

        run_instr(11'b11111111111, 0, 0, 1'b0, "illegal op");
        run_instr(T_ADD, 0, 0, 1'b0, "after illegal");

        // Reset pulled mid-cycle while a store is on the bus.
        step(P_FETCH, 1'b1, 1'b0, T_STUR, "rst-stur fetch");
        step(P_DECODE, 1'b0, 1'b0, T_STUR, "rst-stur decode");
        step(P_MEMADDR, 1'b0, 1'b0, T_STUR, "rst-stur memaddr");
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL memwr before reset: got req=%b we=%b required 1 1", mem_req, mem_we);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL async reset drop: got req=%b we=%b state=%0d required 0 0 0",
                     mem_req, mem_we, state);
        end
        begin
            item_t it;
            it.e = ctl(P_RESET, 1'b0, 1'b0, T_STUR, 1'b0);
            it.ill = 1'b0;
            it.tag = "reset in memwr";
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        step(P_RESET, 1'b1, 1'b0, T_STUR, "reset in memwr");
        reset_n = 1'b1;
        run_instr(T_ADD, 0, 0, 1'b0, "after reset");
        run_instr(T_LDUR, 1, 2, 1'b0, "after reset ld");

        // Fetch never acknowledged: watchdog fires on the MAX_WAIT-th waiting cycle.
        for (int k = 0; k < MAX_WAIT; k++) step(P_FETCH, 1'b0, 1'b0, T_ADD, "wdog fetch");
        exp_berr = 1'b1;
        for (int k = 0; k < 3; k++) step(P_HALT, 1'($urandom), 1'($urandom), T_ADD, "wdog halt");
        do_reset();
        run_instr(T_ADD, 0, 0, 1'b0, "after wdog");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
- Main control FSM for the multicycle LEGv8 datapath.
- Sequences fetch/decode/execute/memory/writeback and drives ALUOp0/ALUOp1 into ALUControl, plus all datapath mux and write enables.
- Sits between the instruction register (opcode = instruction[31:21]) and a shared instruction/data memory with a req/ack handshake.
- Also runs a memory-wait watchdog.

Parameters:
- MAX_WAIT, 255, max cycles mem_req may stay unacknowledged before bus_error; 0 disables the watchdog.
- OPCODE_W, 11, opcode field width (fixed LEGv8 encoding; do not override).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  11  instruction[31:21] from the IR
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write when 1, read when 0 (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- reg2loc  out  1  read register 2 select: 1 = Rt (STUR/CBZ), 0 = Rm
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp0  out  1  to ALUControl
- ALUOp1  out  1  to ALUControl
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback select: 1 = MDR
- state  out  4  current state, for debug
- bus_error  out  1  sticky watchdog flag

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low on reset_n.
  - While reset_n=0: state=FETCH(0), bus_error=0, wait counter=0, every output deasserted (0).
  - Reset asserted mid-instruction aborts it; no partial write is permitted after reset deasserts.
- States:
  - FETCH 0
  - DECODE 1
  - MEMADDR 2
  - MEMRD 3
  - LDWB 4
  - MEMWR 5
  - REXEC 6
  - RWB 7
  - CBZ 8
  - BR 9
  - HALT 15
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=0 (Mealy, same cycle); next state DECODE. Otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, ALUOp=00 (branch target into ALUOut); reg2loc=1 for STUR/CBZ.
  - Dispatch:
    - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000 -> REXEC
    - LDUR 11111000010 / STUR 11111000000 -> MEMADDR
    - opcode[10:3]=10110100 (CBZ) -> CBZ
    - opcode[10:5]=000101 (B) -> BR
    - anything else -> see Optional Feature.
- REXEC: alu_src_a=1, alu_src_b=00, ALUOp1=1, ALUOp0=0 -> RWB.
- RWB: reg_write=1, mem_to_reg=0 -> FETCH.
- MEMADDR: alu_src_a=1, alu_src_b=10, ALUOp=00 -> MEMRD if LDUR, MEMWR if STUR.
- MEMRD: mem_req=1, mem_we=0, iord=1; on mem_ack -> LDWB.
- LDWB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1, reg2loc=1; on mem_ack -> FETCH.
- CBZ: alu_src_a=1, alu_src_b=00, ALUOp0=1, ALUOp1=0, reg2loc=1; pc_write=zero, pc_src=1 -> FETCH.
- BR: pc_write=1, pc_src=1 -> FETCH.
- HALT: all outputs 0; exit only via reset.
- Latency with zero-wait memory (ack in the first request cycle):
  - R-type 4 cycles
  - LDUR 5 cycles
  - STUR 4 cycles
  - CBZ 3 cycles
  - B 3 cycles
- Handshake rules:
  - mem_req holds, with constant mem_we/iord, until the mem_ack cycle.
  - mem_ack outside a requesting state is ignored.
- Watchdog:
  - Counter increments each cycle mem_req=1 && !mem_ack; clears on ack or on leaving the state.
  - When the count reaches MAX_WAIT with still no ack: bus_error<=1 (sticky), next state HALT, no ir_write/pc_write that cycle.
  - An ack arriving in the same cycle as the limit wins (normal progress).
  - Counter width clog2(MAX_WAIT+1), saturating.

Optional Feature:
- Macro: LEGV8_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal (1 bit), reset 0.
  - An undecodable opcode in DECODE sets illegal=1 (sticky) and goes to HALT.
- Undefined:
  - No illegal port.
  - An undecodable opcode is a NOP: DECODE -> FETCH with no writes; PC already advanced in FETCH.

Decomposition:
- Package legv8_pkg:
  - state enum (4-bit encodings above)
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ (8-bit), OP_B (6-bit)
  - ALUOp encodings ALUOP_ADD=00, ALUOP_PASSB=01, ALUOP_FUNCT=10
  - alu_src_b selector constants
- Sub-module: legv8_mem_watchdog (counter + bus_error, parameterised by MAX_WAIT).
- Decode and output logic stay in the top module.

Test Plan:
- Reset, then ADD opcode 10001011000 with ack every request cycle -> states 0,1,6,7,0; reg_write=1 only in state 7; ALUOp1/0=1/0 in state 6.
- LDUR with mem_ack delayed 3 cycles in MEMRD -> mem_req, mem_we=0, iord=1 held 4 cycles; reg_write with mem_to_reg=1 exactly once; total 8 cycles.
- CBZ with zero=1, then a second CBZ with zero=0 -> pc_write=1, pc_src=1 in CBZ state for the first only; both return to FETCH.
- MAX_WAIT=4, FETCH never acked -> bus_error=1 after 4 waiting cycles; state=15; ir_write never 1; stays halted until reset_n=0.
- reset_n pulsed low during MEMWR -> mem_req drops asynchronously; restart in FETCH, no mem_we pulse after release.
- Opcode 11111111111: with LEGV8_ILLEGAL_TRAP_EN -> illegal=1, HALT; without -> returns to FETCH after DECODE, no writes.
